// File: rtl/bcd_seg7_counter.sv
// bcd_seg7_counter: DIGITS-wide BCD up/down counter with prescaler, parallel
// load, wrap pulse and a registered seven-segment decode per digit.
// Optional feature macro: SEG7_BLANK_EN (leading-zero blanking, digit0 never blanks).
module bcd_seg7_counter #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  clean,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  wrap
);

    localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]         presc, presc_nx;
    logic [4*DIGITS-1:0]   bcd_nx;
    logic [7*DIGITS-1:0]   seg_nx;
    logic                  wrap_nx;
    logic                  step;
    logic                  carry;
    logic [3:0]            dig;
    logic [3:0]            nib;

    assign step = en && (presc == PMAX);

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h00;
        endcase
    endfunction

    // Next count, prescaler and wrap: clean > load > step > prescale/hold.
    // clean is folded in here too so the segment decode sees the zero value
    // on the reset edge.
    always_comb begin
        bcd_nx   = bcd;
        presc_nx = presc;
        wrap_nx  = 1'b0;
        carry    = 1'b1;
        dig      = '0;
        nib      = '0;
        if (clean) begin
            bcd_nx   = '0;
            presc_nx = '0;
        end else if (load) begin
            presc_nx = '0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                nib = load_val[4*i +: 4];
                bcd_nx[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
            end
        end else if (step) begin
            presc_nx = '0;
            // Ripple carry/borrow through all digits; carry out of the top is the wrap.
            for (int unsigned i = 0; i < DIGITS; i++) begin
                dig = bcd[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (dig == 4'd9) begin
                            bcd_nx[4*i +: 4] = 4'd0;
                        end else begin
                            bcd_nx[4*i +: 4] = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            bcd_nx[4*i +: 4] = 4'd9;
                        end else begin
                            bcd_nx[4*i +: 4] = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            wrap_nx = carry;
        end else if (en) begin
            presc_nx = presc + 1'b1;
        end
    end

    // Segment decode of the next count, scanned from the top digit so leading
    // zeros can be blanked; polarity applied last so blanked means "off".
    always_comb begin : p_seg
        int unsigned idx;
        logic        seen;
        logic [3:0]  d;
        logic [6:0]  pat;
        seg_nx = '0;
        seen   = 1'b0;
        idx    = 0;
        d      = '0;
        pat    = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            d   = bcd_nx[4*idx +: 4];
            pat = dec7(d);
`ifdef SEG7_BLANK_EN
            if (d != 4'd0) seen = 1'b1;
            if (!seen && idx != 0) pat = '0;
`else
            seen = 1'b1;
`endif
            if (SEG_ACTIVE_LOW != 0) pat = ~pat;
            seg_nx[7*idx +: 7] = pat;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        seg <= seg_nx;
        if (clean) begin
            bcd   <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            bcd   <= bcd_nx;
            presc <= presc_nx;
            wrap  <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_counter.sv
// Directed bench for bcd_seg7_counter: PRESCALE=1 (active-high and active-low
// segment builds sharing stimulus) and PRESCALE=4 with its own stimulus.
// Honours SEG7_BLANK_EN for the expected segment patterns.
module tb_bcd_seg7_counter;

    logic        clk = 1'b0;
    // stimulus shared by the PRESCALE=1 instances
    logic        clean, en, up, load;
    logic [15:0] load_val;
    logic [15:0] bcd_a, bcd_c;
    logic [27:0] seg_a, seg_c;
    logic        wrap_a, wrap_c;
    // stimulus for the PRESCALE=4 instance
    logic        clean_b, en_b, up_b, load_b;
    logic [15:0] load_val_b;
    logic [15:0] bcd_b;
    logic [27:0] seg_b;
    logic        wrap_b;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SEG7_BLANK_EN
    localparam logic [27:0] SEG_0000   = {7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [27:0] SEG_0098   = {7'h00, 7'h00, 7'h6F, 7'h7F};
    localparam logic [27:0] SEG_0100   = {7'h00, 7'h06, 7'h3F, 7'h3F};
    localparam logic [27:0] SEGL_0000  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] SEGL_0100  = {7'h7F, 7'h79, 7'h40, 7'h40};
`else
    localparam logic [27:0] SEG_0000   = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] SEG_0098   = {7'h3F, 7'h3F, 7'h6F, 7'h7F};
    localparam logic [27:0] SEG_0100   = {7'h3F, 7'h06, 7'h3F, 7'h3F};
    localparam logic [27:0] SEGL_0000  = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] SEGL_0100  = {7'h40, 7'h79, 7'h40, 7'h40};
`endif
    localparam logic [27:0] SEG_9999   = {7'h6F, 7'h6F, 7'h6F, 7'h6F};

    bcd_seg7_counter #(.DIGITS(4), .PRESCALE(1), .SEG_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .clean(clean), .en(en), .up(up), .load(load),
        .load_val(load_val), .bcd(bcd_a), .seg(seg_a), .wrap(wrap_a));

    bcd_seg7_counter #(.DIGITS(4), .PRESCALE(1), .SEG_ACTIVE_LOW(1)) dut_c (
        .clk(clk), .clean(clean), .en(en), .up(up), .load(load),
        .load_val(load_val), .bcd(bcd_c), .seg(seg_c), .wrap(wrap_c));

    bcd_seg7_counter #(.DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(0)) dut_b (
        .clk(clk), .clean(clean_b), .en(en_b), .up(up_b), .load(load_b),
        .load_val(load_val_b), .bcd(bcd_b), .seg(seg_b), .wrap(wrap_b));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance n rising edges; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clean = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        clean_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = '0;

        // T1 reset
        tick(2);
        check_eq("rst_bcd", {16'h0, bcd_a}, 32'h0000);
        check_eq("rst_seg", {4'h0, seg_a}, {4'h0, SEG_0000});
        check_eq("rst_wrap", {31'h0, wrap_a}, 32'h0);
        check_eq("rst_seg_al", {4'h0, seg_c}, {4'h0, SEGL_0000});

        // T2 up count from 0098
        clean = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h0098;
        tick(1);
        load = 1'b0;
        check_eq("ld_0098_bcd", {16'h0, bcd_a}, 32'h0098);
        check_eq("ld_0098_seg", {4'h0, seg_a}, {4'h0, SEG_0098});
        tick(1);
        check_eq("up_0099", {16'h0, bcd_a}, 32'h0099);
        tick(1);
        check_eq("up_0100", {16'h0, bcd_a}, 32'h0100);
        check_eq("up_0100_seg", {4'h0, seg_a}, {4'h0, SEG_0100});
        check_eq("up_0100_seg_al", {4'h0, seg_c}, {4'h0, SEGL_0100});
        check_eq("up_0100_wrap", {31'h0, wrap_a}, 32'h0);

        // T3 wrap up then down
        load = 1'b1; load_val = 16'h9999;
        tick(1);
        load = 1'b0;
        check_eq("ld_9999", {16'h0, bcd_a}, 32'h9999);
        check_eq("ld_9999_seg", {4'h0, seg_a}, {4'h0, SEG_9999});
        tick(1);
        en = 1'b0;
        check_eq("wrapup_bcd", {16'h0, bcd_a}, 32'h0000);
        check_eq("wrapup_pulse", {31'h0, wrap_a}, 32'h1);
        check_eq("wrapup_seg", {4'h0, seg_a}, {4'h0, SEG_0000});
        tick(1);
        check_eq("wrapup_end", {31'h0, wrap_a}, 32'h0);
        check_eq("hold_bcd", {16'h0, bcd_a}, 32'h0000);
        en = 1'b1; up = 1'b0;
        tick(1);
        en = 1'b0;
        check_eq("wrapdn_bcd", {16'h0, bcd_a}, 32'h9999);
        check_eq("wrapdn_pulse", {31'h0, wrap_a}, 32'h1);
        tick(1);
        check_eq("wrapdn_end", {31'h0, wrap_a}, 32'h0);
        // borrow chain
        load = 1'b1; load_val = 16'h1000;
        tick(1);
        load = 1'b0; en = 1'b1;
        tick(1);
        check_eq("borrow_0999", {16'h0, bcd_a}, 32'h0999);
        check_eq("borrow_wrap", {31'h0, wrap_a}, 32'h0);

        // T6 reset on a step edge at 0999 (every enabled edge steps here)
        up = 1'b1; clean = 1'b1;
        tick(1);
        check_eq("midrst_bcd", {16'h0, bcd_a}, 32'h0000);
        check_eq("midrst_wrap", {31'h0, wrap_a}, 32'h0);
        check_eq("midrst_seg_al", {4'h0, seg_c}, {4'h0, SEGL_0000});
        clean = 1'b0; en = 1'b0;

        // T4 PRESCALE=4
        clean_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        tick(3);
        check_eq("ps_3cyc", {16'h0, bcd_b}, 32'h0000);
        tick(1);
        check_eq("ps_4cyc", {16'h0, bcd_b}, 32'h0001);
        tick(2);
        en_b = 1'b0;
        tick(3);
        en_b = 1'b1;
        tick(1);
        check_eq("ps_stall_early", {16'h0, bcd_b}, 32'h0001);
        tick(1);
        check_eq("ps_stall_step", {16'h0, bcd_b}, 32'h0002);

        // T5 load while step is due, invalid nibble
        tick(3);
        check_eq("ps_pre_load", {16'h0, bcd_b}, 32'h0002);
        load_b = 1'b1; load_val_b = 16'h12F4;
        tick(1);
        load_b = 1'b0;
        check_eq("ld_inval_bcd", {16'h0, bcd_b}, 32'h1204);
        check_eq("ld_inval_wrap", {31'h0, wrap_b}, 32'h0);
        tick(3);
        check_eq("ld_ps_hold", {16'h0, bcd_b}, 32'h1204);
        tick(1);
        check_eq("ld_ps_step", {16'h0, bcd_b}, 32'h1205);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
